ram_image_writer: RTL and testbench
===================================

RAM_IMAGE_WRITER -- requirements
Module: ram_image_writer

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 256, the byte capacity of the target instruction RAM; only 256 is supported, giving an 8-bit address and a 64-word capacity.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1, synchronous request to restart loading at address 0.
REQ-005 The block SHALL have port wr_valid, input, 1, meaning an instruction word is offered.
REQ-006 The block SHALL have port wr_data, input, 32, the instruction word.
REQ-007 The block SHALL have port wr_ready, output, 1, meaning the block accepts a word this cycle.
REQ-008 The block SHALL have port mem_we, output, 1, the byte write strobe to the 256x8 RAM.
REQ-009 The block SHALL have port mem_addr, output, 8, the byte address.
REQ-010 The block SHALL have port mem_byte, output, 8, the byte write data.
REQ-011 The block SHALL have port word_count, output, 7, the number of complete words written since reset or start (0..64).
REQ-012 The block SHALL have port full, output, 1, meaning all 256 bytes have been written.

Function
REQ-013 The block SHALL implement states IDLE, WRITE and FULL.
REQ-014 Handshake: a word SHALL be accepted on a rising edge where wr_valid=1 and wr_ready=1, with wr_ready = (state==IDLE) and not start.
REQ-015 On accept, the block SHALL capture wr_data, clear byte_idx to 0 and enter WRITE; wr_data is don't-care after the accept edge.
REQ-016 In WRITE, mem_we SHALL be 1, mem_addr SHALL be base+byte_idx, and mem_byte SHALL be big-endian: idx0=[31:24], idx1=[23:16], idx2=[15:8], idx3=[7:0].
REQ-017 byte_idx SHALL increment on each WRITE edge; on the edge with byte_idx=3, word_count SHALL increment and base SHALL advance by 4 (8-bit wrap).
REQ-018 After byte 3, the next state SHALL be FULL if base wraps to 0 (the 64th word), otherwise IDLE.
REQ-019 Outside WRITE, mem_we SHALL be 0, mem_addr SHALL equal base, and mem_byte SHALL be 0.
REQ-020 Latency: the bytes of an accepted word SHALL be written on the 4 cycles following the accept edge; maximum throughput is 1 word per 5 cycles.
REQ-021 In FULL, wr_ready SHALL be 0, full SHALL be 1, and offered words SHALL be ignored with no write.
REQ-022 start in IDLE or FULL SHALL, on the next edge, set base=0, word_count=0 and state=IDLE.
REQ-023 start in WRITE SHALL be ignored; the word in flight completes.
REQ-024 start and wr_valid together in IDLE: start wins and the word is not accepted.
REQ-025 A held wr_valid SHALL be re-accepted only after the block returns to IDLE; no word is written twice per handshake.

Reset
REQ-026 reset_n=0 SHALL immediately, independent of clk, force state=IDLE, base=0, byte_idx=0, word_count=0, full=0, mem_we=0, mem_addr=0 and mem_byte=0.
REQ-027 wr_ready SHALL be 0 while reset_n=0 and becomes 1 on the first cycle after release when start=0.
REQ-028 Reset during WRITE SHALL abort the partial word with no further mem_we; bytes already written stay in the RAM.

Verification
REQ-029 Single word: after reset, offer 0xE3A01005 -> writes 0xE3, 0xA0, 0x10, 0x05 at addresses 0..3 on 4 consecutive cycles; word_count=1; wr_ready=1 again on the 5th cycle.
REQ-030 Back-to-back: wr_valid held with words 0x11223344 then 0x55667788 -> second accepted exactly 5 cycles after the first; bytes land at addresses 4..7 as 0x55, 0x66, 0x77, 0x88.
REQ-031 Fill: 64 words -> last write at address 255, full=1, word_count=64; a 65th offer sees wr_ready=0 with no mem_we; start -> IDLE, base=0, count=0.
REQ-032 Start during WRITE at byte_idx=1 -> bytes 2 and 3 are still written and word_count increments; start asserted in the following IDLE cycle resets base to 0.
REQ-033 Async reset at byte_idx=2 -> mem_we drops within the same cycle with no clk edge; after release, the next word is written at address 0.
REQ-034 Readback: load 9 words, then read addresses 0,4,...,32 via the RAM read port -> each 32-bit word equals the offered word (big-endian).

Source files
------------

// File: rtl/ram_image_writer.sv
// Streams 32-bit instruction words into a byte-wide RAM, one byte per cycle, big-endian.
// Tracks the number of words written and stops accepting once the RAM is full.
module ram_image_writer #(
  parameter int MEM_BYTES = 256
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        wr_valid,
  input  logic [31:0] wr_data,
  output logic        wr_ready,
  output logic        mem_we,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_byte,
  output logic [6:0]  word_count,
  output logic        full
);

  localparam logic [8:0] END_ADDR = 9'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, WRITE, FULL} state_t;

  state_t      state, state_nxt;
  logic [7:0]  base, base_nxt;
  logic [1:0]  byte_idx, byte_idx_nxt;
  logic [6:0]  count_nxt;
  logic [31:0] word_p0;
  logic        accept;
  logic [8:0]  base_sum;

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[31:24];
      2'd1:    b = w[23:16];
      2'd2:    b = w[15:8];
      default: b = w[7:0];
    endcase
    return b;
  endfunction

  assign wr_ready = reset_n && (state == IDLE) && !start;
  assign accept   = wr_ready && wr_valid;
  assign base_sum = {1'b0, base} + 9'd4;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      base       <= 8'd0;
      byte_idx   <= 2'd0;
      word_count <= 7'd0;
    end else begin
      state      <= state_nxt;
      base       <= base_nxt;
      byte_idx   <= byte_idx_nxt;
      word_count <= count_nxt;
    end
  end

  // Capture stage: the word is held only while its bytes are being written
  always_ff @(posedge clk) begin
    if (accept) begin
      word_p0 <= wr_data;
    end
  end

  always_comb begin
    state_nxt    = state;
    base_nxt     = base;
    byte_idx_nxt = byte_idx;
    count_nxt    = word_count;
    case (state)
      IDLE: begin
        if (start) begin
          base_nxt  = 8'd0;
          count_nxt = 7'd0;
        end else if (wr_valid) begin
          state_nxt    = WRITE;
          byte_idx_nxt = 2'd0;
        end
      end
      WRITE: begin
        byte_idx_nxt = byte_idx + 2'd1;
        if (byte_idx == 2'd3) begin
          count_nxt = word_count + 7'd1;
          base_nxt  = base_sum[7:0];
          // Reaching the end of the RAM means the 64th word just completed
          state_nxt = (base_sum == END_ADDR) ? FULL : IDLE;
        end
      end
      FULL: begin
        if (start) begin
          state_nxt = IDLE;
          base_nxt  = 8'd0;
          count_nxt = 7'd0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write stage: byte lane selected by byte_idx, address offset from the word base
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = base;
    mem_byte = 8'd0;
    if (state == WRITE) begin
      mem_we   = 1'b1;
      mem_addr = base + {6'd0, byte_idx};
      mem_byte = pick_byte(word_p0, byte_idx);
    end
  end

  assign full = (state == FULL);

endmodule

// File: tb/tb_ram_image_writer.sv
// Directed bench for ram_image_writer: expected byte writes are queued when a word is
// offered and popped by a monitor that also mirrors the RAM for readback checks.
module tb_ram_image_writer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = 32'd0;
  logic        wr_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_byte;
  logic [6:0]  word_count;
  logic        full;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_q[$];
  logic [7:0]  ram [256];
  logic [7:0]  exp_base = 8'd0;
  logic [7:0]  last_addr = 8'd0;
  logic [31:0] rb_words [9];
  time         t1, t2;

  always #5 clk = ~clk;

  ram_image_writer #(.MEM_BYTES(256)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_byte   (mem_byte),
    .word_count (word_count),
    .full       (full)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    logic [15:0] e;
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("we_unexpected", {31'd0, mem_we}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", {24'd0, mem_addr}, {24'd0, e[15:8]});
        check("wr_byte", {24'd0, mem_byte}, {24'd0, e[7:0]});
      end
      ram[mem_addr] = mem_byte;
      last_addr = mem_addr;
    end
  end

  task automatic push_exp(input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({exp_base + 8'(i), w[31-8*i -: 8]});
    end
    exp_base = exp_base + 8'd4;
  endtask

  task automatic wait_accept(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (wr_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, wr_ready}, 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic put_word(input logic [31:0] w);
    wr_valid = 1'b1;
    wr_data  = w;
    push_exp(w);
    wait_accept("accept");
    wr_valid = 1'b0;
    wr_data  = 32'hDEAD_BEEF;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    exp_base = 8'd0;
  endtask

  initial begin
    // Reset state, no clock edge involved
    #2;
    check("rst_ready", {31'd0, wr_ready}, 32'd0);
    check("rst_we", {31'd0, mem_we}, 32'd0);
    check("rst_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_byte", {24'd0, mem_byte}, 32'd0);
    check("rst_count", {25'd0, word_count}, 32'd0);
    check("rst_full", {31'd0, full}, 32'd0);
    #10;
    reset_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {31'd0, wr_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Single word
    put_word(32'hE3A0_1005);
    @(negedge clk);
    check("busy_idx0", {31'd0, wr_ready}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("busy_idx3", {31'd0, wr_ready}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("ready_5th", {31'd0, wr_ready}, 32'd1);
    check("count_one", {25'd0, word_count}, 32'd1);
    check("base_four", {24'd0, mem_addr}, 32'd4);
    check("idle_byte", {24'd0, mem_byte}, 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back with wr_valid held
    pulse_start();
    wr_valid = 1'b1;
    wr_data  = 32'h1122_3344;
    push_exp(32'h1122_3344);
    wait_accept("b2b_first");
    t1 = $time;
    wr_data = 32'h5566_7788;
    push_exp(32'h5566_7788);
    wait_accept("b2b_second");
    t2 = $time;
    wr_valid = 1'b0;
    check("b2b_gap", 32'(t2 - t1), 32'd50);
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("b2b_count", {25'd0, word_count}, 32'd2);
    check("b2b_last_addr", {24'd0, last_addr}, 32'd7);
    @(posedge clk);
    #1;

    // Fill all 64 words
    pulse_start();
    for (int i = 0; i < 64; i++) begin
      put_word($urandom);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("fill_full", {31'd0, full}, 32'd1);
    check("fill_count", {25'd0, word_count}, 32'd64);
    check("fill_last_addr", {24'd0, last_addr}, 32'd255);
    check("fill_base", {24'd0, mem_addr}, 32'd0);
    @(posedge clk);
    #1;
    wr_valid = 1'b1;
    wr_data  = 32'hCAFE_F00D;
    repeat (6) @(negedge clk);
    check("full_ready", {31'd0, wr_ready}, 32'd0);
    check("full_count_hold", {25'd0, word_count}, 32'd64);
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    pulse_start();
    @(negedge clk);
    check("restart_full", {31'd0, full}, 32'd0);
    check("restart_count", {25'd0, word_count}, 32'd0);
    check("restart_base", {24'd0, mem_addr}, 32'd0);
    check("restart_ready", {31'd0, wr_ready}, 32'd1);
    @(posedge clk);
    #1;

    // Start during WRITE is ignored; start wins over wr_valid in IDLE
    put_word(32'hA1B2_C3D4);
    repeat (4) @(posedge clk);
    #1;
    put_word(32'h0102_0304);
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("mid_start_count", {25'd0, word_count}, 32'd2);
    check("mid_start_base", {24'd0, mem_addr}, 32'd8);
    @(posedge clk);
    #1;
    start    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = 32'h7777_7777;
    @(negedge clk);
    check("start_wins_ready", {31'd0, wr_ready}, 32'd0);
    @(posedge clk);
    #1;
    start    = 1'b0;
    wr_valid = 1'b0;
    exp_base = 8'd0;
    @(negedge clk);
    check("start_idle_base", {24'd0, mem_addr}, 32'd0);
    check("start_idle_count", {25'd0, word_count}, 32'd0);
    check("start_idle_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a word
    put_word(32'h9988_7766);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2;
    check("pre_abort_we", {31'd0, mem_we}, 32'd1);
    reset_n = 1'b0;
    #1;
    check("abort_we", {31'd0, mem_we}, 32'd0);
    check("abort_addr", {24'd0, mem_addr}, 32'd0);
    check("abort_ready", {31'd0, wr_ready}, 32'd0);
    check("abort_count", {25'd0, word_count}, 32'd0);
    #4;
    reset_n = 1'b1;
    exp_q.delete();
    exp_base = 8'd0;
    @(posedge clk);
    #1;
    put_word(32'h0BAD_F00D);
    repeat (5) @(posedge clk);
    #1;
    check("post_abort_ram0", {24'd0, ram[0]}, 32'h0B);
    check("post_abort_count", {25'd0, word_count}, 32'd1);

    // Readback through the mirrored RAM
    pulse_start();
    for (int i = 0; i < 9; i++) begin
      rb_words[i] = $urandom;
      put_word(rb_words[i]);
    end
    repeat (5) @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      check("readback", {ram[4*i], ram[4*i+1], ram[4*i+2], ram[4*i+3]}, rb_words[i]);
    end
    check("rb_count", {25'd0, word_count}, 32'd9);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
